// File: rtl/mcu_pin_bridge_pkg.sv
// Shared definitions for the MCU pin bridge: FSM encodings, bank count and register-map bases.
package mcu_pin_bridge_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_ACK    = 2'd2;

  // Register regions, in address order; each spans NBANKS addresses except ID.
  localparam int REG_OUT  = 0;
  localparam int REG_DIR  = 1;
  localparam int REG_IN   = 2;
  localparam int REG_EDGE = 3;
  localparam int REG_ID   = 4;

  function automatic int nbanks(input int pins, input int dw);
    return (pins + dw - 1) / dw;
  endfunction

  function automatic int region_base(input int region, input int nb);
    return region * nb;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// N-bit two-flop synchroniser with asynchronous active-low reset.
module pin_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mcu_pin_bridge.sv
// Asynchronous MCU bus to PINS_COUNT bidirectional pins via OUT/DIR/IN/ID banks.
// Define PIN_EDGE_EN to add sticky rising-edge capture banks and the irq output.
module mcu_pin_bridge
  import mcu_pin_bridge_pkg::*;
#(
  parameter int PINS_COUNT = 132,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8
) (
  input  logic                  CLK50,
  input  logic                  RST_N,
  inout  wire  [DATA_W-1:0]     data,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  mcu_mstr,
  input  logic                  write_enable,
  output logic                  fpga_ready,
  inout  wire  [PINS_COUNT-1:0] io_pins,
  output logic                  irq
);

  localparam int NB     = nbanks(PINS_COUNT, DATA_W);
  localparam int PADW   = NB * DATA_W;
  localparam int B_OUT  = region_base(REG_OUT,  NB);
  localparam int B_DIR  = region_base(REG_DIR,  NB);
  localparam int B_IN   = region_base(REG_IN,   NB);
  localparam int B_EDGE = region_base(REG_EDGE, NB);
  localparam int B_ID   = region_base(REG_ID,   NB);

  logic                  w_ms_s;
  logic [PINS_COUNT-1:0] w_pin_s;
  logic [PINS_COUNT-1:0] r_out;
  logic [PINS_COUNT-1:0] r_dir;
  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdq;
  logic [DATA_W-1:0]     w_rd;
  logic                  w_wr_stb;
  logic [PADW-1:0]       w_out_pad;
  logic [PADW-1:0]       w_dir_pad;
  logic [PADW-1:0]       w_in_pad;
  logic [PADW-1:0]       w_edge_pad;

  pin_sync #(.N(1)) u_ms_sync (
    .clk   (CLK50),
    .rst_n (RST_N),
    .i_d   (mcu_mstr),
    .o_q   (w_ms_s)
  );

  pin_sync #(.N(PINS_COUNT)) u_pin_sync (
    .clk   (CLK50),
    .rst_n (RST_N),
    .i_d   (io_pins),
    .o_q   (w_pin_s)
  );

  assign w_wr_stb  = (r_state == ST_ACCESS) && r_we;
  // Zero-padding makes the missing top bits of the last bank read back as 0.
  assign w_out_pad = PADW'(r_out);
  assign w_dir_pad = PADW'(r_dir);
  assign w_in_pad  = PADW'(w_pin_s);

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdq   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ms_s) begin
            r_addr  <= address;
            r_we    <= write_enable;
            r_wdata <= data;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_we) r_rdq <= w_rd;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          if (!w_ms_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      r_out <= '0;
      r_dir <= '0;
    end else if (w_wr_stb) begin
      for (int i = 0; i < PINS_COUNT; i++) begin
        if (r_addr == ADDR_W'(B_OUT + i / DATA_W)) r_out[i] <= r_wdata[i % DATA_W];
        if (r_addr == ADDR_W'(B_DIR + i / DATA_W)) r_dir[i] <= r_wdata[i % DATA_W];
      end
    end
  end

  // Unmatched addresses fall through to 0.
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NB; k++) begin
      if (r_addr == ADDR_W'(B_OUT  + k)) w_rd = w_out_pad[k*DATA_W +: DATA_W];
      if (r_addr == ADDR_W'(B_DIR  + k)) w_rd = w_dir_pad[k*DATA_W +: DATA_W];
      if (r_addr == ADDR_W'(B_IN   + k)) w_rd = w_in_pad[k*DATA_W +: DATA_W];
      if (r_addr == ADDR_W'(B_EDGE + k)) w_rd = w_edge_pad[k*DATA_W +: DATA_W];
    end
    if (r_addr == ADDR_W'(B_ID)) w_rd = DATA_W'(PINS_COUNT);
  end

`ifdef PIN_EDGE_EN
  logic [PINS_COUNT-1:0] r_edge;
  logic [PINS_COUNT-1:0] r_pin_prev;
  logic                  r_irq;

  // A rising edge in the same cycle as a write-1-to-clear keeps the bit set.
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      r_edge     <= '0;
      r_pin_prev <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_pin_prev <= w_pin_s;
      r_irq      <= |r_edge;
      for (int i = 0; i < PINS_COUNT; i++) begin
        if (w_pin_s[i] && !r_pin_prev[i])
          r_edge[i] <= 1'b1;
        else if (w_wr_stb && (r_addr == ADDR_W'(B_EDGE + i / DATA_W)) && r_wdata[i % DATA_W])
          r_edge[i] <= 1'b0;
      end
    end
  end

  assign w_edge_pad = PADW'(r_edge);
  assign irq        = r_irq;
`else
  assign w_edge_pad = '0;
  assign irq        = 1'b0;
`endif

  for (genvar gi = 0; gi < PINS_COUNT; gi++) begin : g_pin
    assign io_pins[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
  end

  assign fpga_ready = (r_state == ST_ACK);
  assign data       = ((r_state == ST_ACK) && !r_we) ? r_rdq : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mcu_pin_bridge.sv
// Directed bench for mcu_pin_bridge at default parameters; covers PIN_EDGE_EN when defined.
module tb_mcu_pin_bridge;

  localparam int PINS = 132;

  logic            CLK50 = 1'b0;
  logic            RST_N = 1'b0;
  logic            mcu_mstr = 1'b0;
  logic            write_enable = 1'b0;
  logic [7:0]      address = '0;
  logic [7:0]      tb_dout = '0;
  logic            tb_den = 1'b0;
  logic [PINS-1:0] tb_pdrv = '0;
  logic [PINS-1:0] tb_pen = '0;
  wire  [7:0]      data;
  wire  [PINS-1:0] io_pins;
  wire             fpga_ready;
  wire             irq;

  int n_pass = 0;
  int n_tot  = 0;

  assign data = tb_den ? tb_dout : 8'bz;
  for (genvar g = 0; g < PINS; g++) begin : g_tbpin
    assign io_pins[g] = tb_pen[g] ? tb_pdrv[g] : 1'bz;
  end

  always #10 CLK50 = ~CLK50;

  mcu_pin_bridge #(.PINS_COUNT(PINS), .DATA_W(8), .ADDR_W(8)) dut (
    .CLK50        (CLK50),
    .RST_N        (RST_N),
    .data         (data),
    .address      (address),
    .mcu_mstr     (mcu_mstr),
    .write_enable (write_enable),
    .fpga_ready   (fpga_ready),
    .io_pins      (io_pins),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Full 4-phase transaction; up/dn count falling edges to ready rise/fall.
  task automatic xfer(input logic [7:0] a, input logic we, input logic [7:0] wd,
                      output logic [7:0] rd, output int up, output int dn);
    @(negedge CLK50);
    address = a; write_enable = we; tb_dout = wd; tb_den = we; mcu_mstr = 1'b1;
    up = 0;
    do begin @(negedge CLK50); up++; end while (fpga_ready !== 1'b1 && up < 20);
    chk("ack_seen", fpga_ready, 1);
    rd = data;
    mcu_mstr = 1'b0; tb_den = 1'b0;
    dn = 0;
    do begin @(negedge CLK50); dn++; end while (fpga_ready !== 1'b0 && dn < 20);
    chk("ack_drop", fpga_ready, 0);
  endtask

  initial begin
    logic [7:0] rd;
    int up, dn;
    logic ok;

    repeat (3) @(negedge CLK50);
    chk("rst_ready", fpga_ready, 0);
    chk("rst_irq", irq, 0);
    chk("rst_data_rel", (|data) !== 1'b1, 1);
    chk("rst_pins_rel", (|io_pins) !== 1'b1, 1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK50);

    xfer(8'd17, 1'b1, 8'hFF, rd, up, dn);
    chk("wr_ack_lat", up, 4);
    chk("wr_drop_lat", dn, 3);
    xfer(8'd0, 1'b1, 8'hA5, rd, up, dn);
    @(negedge CLK50);
    chk("pins_bank0", io_pins[7:0], 8'hA5);
    chk("pins_hi_rel", (|io_pins[131:8]) !== 1'b1, 1);

    xfer(8'd0, 1'b0, 8'h00, rd, up, dn);
    chk("rd_out0", rd, 8'hA5);
    chk("rd_ack_lat", up, 4);
    xfer(8'd17, 1'b0, 8'h00, rd, up, dn);
    chk("rd_dir0", rd, 8'hFF);
    xfer(8'd34, 1'b0, 8'h00, rd, up, dn);
    chk("rd_in0", rd, 8'hA5);

    tb_pen[131:128] = 4'hF; tb_pdrv[131:128] = 4'hF;
    repeat (3) @(negedge CLK50);
    xfer(8'd50, 1'b0, 8'h00, rd, up, dn);
    chk("rd_in16_partial", rd, 8'h0F);
    xfer(8'd68, 1'b0, 8'h00, rd, up, dn);
    chk("rd_id", rd, 8'h84);
    xfer(8'd200, 1'b0, 8'h00, rd, up, dn);
    chk("rd_unmapped", rd, 8'h00);
    chk("unmapped_ack_lat", up, 4);

    xfer(8'd200, 1'b1, 8'hFF, rd, up, dn);
    xfer(8'd0, 1'b0, 8'h00, rd, up, dn);
    chk("unmapped_wr_out0", rd, 8'hA5);
    xfer(8'd17, 1'b0, 8'h00, rd, up, dn);
    chk("unmapped_wr_dir0", rd, 8'hFF);
    chk("unmapped_wr_pins", io_pins[7:0], 8'hA5);

    // Long strobe: ack and read data held while mcu_mstr stays high.
    @(negedge CLK50);
    address = 8'd0; write_enable = 1'b0; mcu_mstr = 1'b1;
    up = 0;
    do begin @(negedge CLK50); up++; end while (fpga_ready !== 1'b1 && up < 20);
    chk("hold_ack", fpga_ready, 1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge CLK50);
      if (fpga_ready !== 1'b1 || data !== 8'hA5) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    mcu_mstr = 1'b0;
    dn = 0;
    do begin @(negedge CLK50); dn++; end while (fpga_ready !== 1'b0 && dn < 20);
    chk("hold_drop_lat", dn, 3);
    chk("hold_data_rel", (|data) !== 1'b1, 1);

    @(negedge CLK50); mcu_mstr = 1'b1;
    @(negedge CLK50); mcu_mstr = 1'b0;
    repeat (10) @(negedge CLK50);
    chk("glitch_ready_low", fpga_ready, 0);
    chk("glitch_data_rel", (|data) !== 1'b1, 1);
    xfer(8'd68, 1'b0, 8'h00, rd, up, dn);
    chk("glitch_then_rd", rd, 8'h84);

    // Reset while acknowledging a read, strobe kept high across reset.
    @(negedge CLK50);
    address = 8'd17; write_enable = 1'b0; mcu_mstr = 1'b1;
    up = 0;
    do begin @(negedge CLK50); up++; end while (fpga_ready !== 1'b1 && up < 20);
    chk("mid_ack", fpga_ready, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_ready", fpga_ready, 0);
    chk("mid_rst_data_rel", (|data) !== 1'b1, 1);
    chk("mid_rst_pins_rel", (|io_pins[127:0]) !== 1'b1, 1);
    @(negedge CLK50);
    RST_N = 1'b1;
    up = 0;
    do begin @(negedge CLK50); up++; end while (fpga_ready !== 1'b1 && up < 20);
    chk("post_rst_ack", fpga_ready, 1);
    chk("post_rst_lat", up, 4);
    chk("post_rst_dir0", data, 8'h00);
    mcu_mstr = 1'b0;
    dn = 0;
    do begin @(negedge CLK50); dn++; end while (fpga_ready !== 1'b0 && dn < 20);
    chk("post_rst_drop_lat", dn, 3);

`ifdef PIN_EDGE_EN
    xfer(8'd67, 1'b1, 8'hFF, rd, up, dn);
    repeat (3) @(negedge CLK50);
    chk("edge_irq_idle", irq, 0);
    tb_pen[9] = 1'b1; tb_pdrv[9] = 1'b0;
    repeat (3) @(negedge CLK50);
    tb_pdrv[9] = 1'b1;
    repeat (5) @(negedge CLK50);
    chk("edge_irq_set", irq, 1);
    xfer(8'd52, 1'b0, 8'h00, rd, up, dn);
    chk("edge_bit", rd, 8'h02);

    tb_pdrv[9] = 1'b0;
    repeat (4) @(negedge CLK50);
    // Pin rises so that its edge lands on the same clock as the clearing write.
    @(negedge CLK50);
    address = 8'd52; write_enable = 1'b1; tb_dout = 8'h02; tb_den = 1'b1; mcu_mstr = 1'b1;
    @(negedge CLK50);
    tb_pdrv[9] = 1'b1;
    up = 1;
    do begin @(negedge CLK50); up++; end while (fpga_ready !== 1'b1 && up < 20);
    chk("edge_race_ack", up, 4);
    mcu_mstr = 1'b0; tb_den = 1'b0;
    dn = 0;
    do begin @(negedge CLK50); dn++; end while (fpga_ready !== 1'b0 && dn < 20);
    xfer(8'd52, 1'b0, 8'h00, rd, up, dn);
    chk("edge_set_wins", rd, 8'h02);
    chk("edge_set_wins_irq", irq, 1);

    xfer(8'd52, 1'b1, 8'h02, rd, up, dn);
    repeat (3) @(negedge CLK50);
    xfer(8'd52, 1'b0, 8'h00, rd, up, dn);
    chk("edge_cleared", rd, 8'h00);
    chk("edge_irq_cleared", irq, 0);
`else
    tb_pen[9] = 1'b1; tb_pdrv[9] = 1'b0;
    repeat (3) @(negedge CLK50);
    tb_pdrv[9] = 1'b1;
    repeat (5) @(negedge CLK50);
    xfer(8'd52, 1'b0, 8'h00, rd, up, dn);
    chk("edge_unmapped", rd, 8'h00);
    chk("irq_tied_low", irq, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
